// File: rtl/mem_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the shared memory and mem_arbiter.
// The master modport is the arbiter side. The slave modport is the requesters plus the memory.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
               mem_rdata, mem_ready,
        output if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
               mem_rdata, mem_ready,
        input  if_ready, if_rdata, if_err, d_ready, d_rdata, d_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between an instruction fetch port and an RV32I load/store port.
//   state | meaning
//   IDLE  | no access in flight, arbitrate (data beats fetch)
//   FETCH | fetch access on the memory, waiting for mem_ready or timeout
//   DATA  | load/store access on the memory, waiting for mem_ready or timeout
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_if_ready;
    logic        r_if_err;
    logic [31:0] r_if_rdata;
    logic        r_d_ready;
    logic        r_d_err;
    logic [31:0] r_d_rdata;

    logic        w_d_elig;
    logic        w_if_elig;
    logic        w_d_bad;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [7:0]  w_cnt_inc;
    logic        w_timeout;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // A requester still showing its ready pulse is holding a stale request.
    assign w_d_elig  = bus.d_req  & ~r_d_ready;
    assign w_if_elig = bus.if_req & ~r_if_ready;

    assign w_d_bad = (bus.d_funct3[1:0] == 2'b11)
                   | (~bus.d_we & (bus.d_funct3 == 3'b110))
                   | (bus.d_we & bus.d_funct3[2])
                   | ((bus.d_funct3[1:0] == 2'b01) & bus.d_addr[0])
                   | ((bus.d_funct3[1:0] == 2'b10) & (bus.d_addr[1:0] != 2'b00));

    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = bus.d_wdata;
        case (bus.d_funct3[1:0])
            2'b00: begin
                w_st_be    = 4'b0001 << bus.d_addr[1:0];
                w_st_wdata = {4{bus.d_wdata[7:0]}};
            end
            2'b01: begin
                w_st_be    = 4'b0011 << bus.d_addr[1:0];
                w_st_wdata = {2{bus.d_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_timeout = (w_cnt_inc == TIMEOUT_CNT);

    always_comb begin
        w_byte = bus.mem_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            2'd3:    w_byte = bus.mem_rdata[31:24];
            default: ;
        endcase
        w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        w_load = bus.mem_rdata;
        case (r_funct3[1:0])
            2'b00:   w_load = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
            2'b01:   w_load = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_off       <= 2'd0;
            r_funct3    <= 3'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_if_ready  <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_d_ready   <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= 32'd0;
        end else begin
            r_if_ready <= 1'b0;
            r_if_err   <= 1'b0;
            r_d_ready  <= 1'b0;
            r_d_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt <= 8'd0;
                    if (w_d_elig) begin
                        if (w_d_bad) begin
                            r_d_ready <= 1'b1;
                            r_d_err   <= 1'b1;
                        end else begin
                            r_state     <= DATA;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.d_we;
                            r_mem_be    <= bus.d_we ? w_st_be : 4'b1111;
                            r_mem_addr  <= {bus.d_addr[31:2], 2'b00};
                            r_mem_wdata <= w_st_wdata;
                            r_off       <= bus.d_addr[1:0];
                            r_funct3    <= bus.d_funct3;
                        end
                    end else if (w_if_elig) begin
                        r_state    <= FETCH;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_be   <= 4'b1111;
                        r_mem_addr <= {bus.if_addr[31:2], 2'b00};
                        r_off      <= bus.if_addr[1:0];
                        r_funct3   <= 3'b010;
                    end
                end
                FETCH, DATA: begin
                    if (bus.mem_ready || w_timeout) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_mem_be  <= 4'd0;
                        if (r_state == FETCH) begin
                            r_if_ready <= 1'b1;
                            r_if_err   <= ~bus.mem_ready;
                            if (bus.mem_ready) r_if_rdata <= bus.mem_rdata;
                        end else begin
                            r_d_ready <= 1'b1;
                            r_d_err   <= ~bus.mem_ready;
                            if (bus.mem_ready) r_d_rdata <= w_load;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.if_err    = r_if_err;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_ready   = r_d_ready;
    assign bus.d_err     = r_d_err;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the stimulus queues the expected completions,
// and a negedge monitor pops and checks each ready pulse.
module tb_mem_arbiter;
    localparam int TIMEOUT = 15;

    logic clk;
    logic rst;
    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          err;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_d = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_d, input bit err, input bit cd, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.err = err;
        e.chk_data = cd;
        e.data = data;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.if_ready || bus.d_ready)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: if_ready=%b d_ready=%b with nothing expected",
                         bus.if_ready, bus.d_ready);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_d_ready", 32'(bus.d_ready), 32'(e.is_d));
                chk("sb_if_ready", 32'(bus.if_ready), 32'(!e.is_d));
                chk("sb_err", 32'(e.is_d ? bus.d_err : bus.if_err), 32'(e.err));
                if (e.chk_data)
                    chk("sb_rdata", e.is_d ? bus.d_rdata : bus.if_rdata, e.data);
            end
        end
    end

    task automatic fetch_ok(input logic [31:0] addr, input logic [31:0] rdata, input int lat,
                            input string name);
        bus.if_req = 1'b1;
        bus.if_addr = addr;
        push(1'b0, 1'b0, 1'b1, rdata);
        tick();
        chk({name, "_mem_req"}, 32'(bus.mem_req), 32'd1);
        chk({name, "_mem_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
        chk({name, "_mem_be"}, 32'(bus.mem_be), 32'hF);
        chk({name, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        for (int i = 1; i < lat; i++) begin
            chk({name, "_early_ready"}, 32'(bus.if_ready), 32'd0);
            tick();
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata;
        tick();
        chk({name, "_if_ready"}, 32'(bus.if_ready), 32'd1);
        chk({name, "_idle_req"}, 32'(bus.mem_req), 32'd0);
        bus.mem_ready = 1'b0;
        bus.if_req = 1'b0;
        tick();
        chk({name, "_pulse_end"}, 32'(bus.if_ready), 32'd0);
        chk({name, "_rdata_hold"}, bus.if_rdata, rdata);
    endtask

    task automatic data_ok(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input logic [3:0] be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd, input int lat, input string name);
        bus.d_req = 1'b1;
        bus.d_we = we;
        bus.d_funct3 = f3;
        bus.d_addr = addr;
        bus.d_wdata = wdata;
        push(1'b1, 1'b0, !we, exp_rd);
        tick();
        chk({name, "_mem_req"}, 32'(bus.mem_req), 32'd1);
        chk({name, "_mem_we"}, 32'(bus.mem_we), 32'(we));
        chk({name, "_mem_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
        chk({name, "_mem_be"}, 32'(bus.mem_be), 32'(be));
        if (we) chk({name, "_mem_wdata"}, bus.mem_wdata, exp_wd);
        for (int i = 1; i < lat; i++) begin
            chk({name, "_early_ready"}, 32'(bus.d_ready), 32'd0);
            tick();
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata;
        tick();
        chk({name, "_d_ready"}, 32'(bus.d_ready), 32'd1);
        chk({name, "_busy"}, 32'(bus.busy), 32'd0);
        bus.mem_ready = 1'b0;
        bus.d_req = 1'b0;
        tick();
        chk({name, "_pulse_end"}, 32'(bus.d_ready), 32'd0);
        if (!we) exp_d = exp_rd;
    endtask

    task automatic reject(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                          input string name);
        bus.d_req = 1'b1;
        bus.d_we = we;
        bus.d_funct3 = f3;
        bus.d_addr = addr;
        bus.d_wdata = 32'h5A5A5A5A;
        push(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        chk({name, "_d_err"}, 32'(bus.d_err), 32'd1);
        chk({name, "_no_mem_req"}, 32'(bus.mem_req), 32'd0);
        chk({name, "_rdata_hold"}, bus.d_rdata, exp_d);
        bus.d_req = 1'b0;
        tick();
        chk({name, "_still_idle"}, 32'(bus.mem_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.if_req = 1'b0;
        bus.if_addr = 32'd0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_funct3 = 3'd0;
        bus.d_addr = 32'd0;
        bus.d_wdata = 32'd0;
        bus.mem_rdata = 32'd0;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        rst = 1'b0;
        tick();

        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hDEADBEEF;
        tick();
        tick();
        chk("idle_mem_ready_busy", 32'(bus.busy), 32'd0);
        chk("idle_mem_ready_rdata", bus.if_rdata, 32'd0);
        bus.mem_ready = 1'b0;

        fetch_ok(32'h0000_0104, 32'h00A0_0093, 1, "fetch");
        fetch_ok(32'h0000_010B, 32'hCAFE_F00D, 4, "fetch_lat4");

        data_ok(1'b1, 3'b000, 32'h203, 32'h0000_00AB, 32'h0, 4'b1000, 32'hABAB_ABAB, 32'h0, 1, "sb");
        data_ok(1'b1, 3'b001, 32'h202, 32'h0000_1234, 32'h0, 4'b1100, 32'h1234_1234, 32'h0, 2, "sh");
        data_ok(1'b1, 3'b000, 32'h200, 32'hFFFF_FF3C, 32'h0, 4'b0001, 32'h3C3C_3C3C, 32'h0, 1, "sb0");
        data_ok(1'b1, 3'b010, 32'h204, 32'h8765_4321, 32'h0, 4'b1111, 32'h8765_4321, 32'h0, 1, "sw");

        data_ok(1'b0, 3'b000, 32'h202, 32'h0, 32'h80FF_7F01, 4'hF, 32'h0, 32'hFFFF_FFFF, 1, "lb");
        data_ok(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_7F01, 4'hF, 32'h0, 32'h0000_0080, 1, "lbu");
        data_ok(1'b0, 3'b001, 32'h200, 32'h0, 32'h80FF_7F01, 4'hF, 32'h0, 32'h0000_7F01, 3, "lh");
        data_ok(1'b0, 3'b001, 32'h202, 32'h0, 32'h80FF_7F01, 4'hF, 32'h0, 32'hFFFF_80FF, 1, "lh_hi");
        data_ok(1'b0, 3'b101, 32'h202, 32'h0, 32'h80FF_7F01, 4'hF, 32'h0, 32'h0000_80FF, 1, "lhu");
        data_ok(1'b0, 3'b010, 32'h204, 32'h0, 32'h80FF_7F01, 4'hF, 32'h0, 32'h80FF_7F01, 2, "lw");

        // Simultaneous requests: data wins, fetch follows right after d_ready.
        bus.if_req = 1'b1;
        bus.if_addr = 32'h300;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_funct3 = 3'b010;
        bus.d_addr = 32'h200;
        push(1'b1, 1'b0, 1'b1, 32'h1122_3344);
        push(1'b0, 1'b0, 1'b1, 32'h5566_7788);
        tick();
        chk("both_data_first", bus.mem_addr, 32'h200);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1122_3344;
        tick();
        chk("both_d_ready", 32'(bus.d_ready), 32'd1);
        chk("both_no_if_ready", 32'(bus.if_ready), 32'd0);
        bus.d_req = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        chk("both_fetch_req", 32'(bus.mem_req), 32'd1);
        chk("both_fetch_addr", bus.mem_addr, 32'h300);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5566_7788;
        tick();
        chk("both_if_ready", 32'(bus.if_ready), 32'd1);
        bus.if_req = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        exp_d = 32'h1122_3344;

        reject(1'b1, 3'b010, 32'h201, "sw_misalign");
        reject(1'b0, 3'b010, 32'h202, "lw_misalign");
        reject(1'b0, 3'b001, 32'h201, "lh_misalign");
        reject(1'b0, 3'b101, 32'h203, "lhu_misalign");
        reject(1'b0, 3'b011, 32'h200, "f3_11");
        reject(1'b0, 3'b110, 32'h200, "load_110");
        reject(1'b1, 3'b100, 32'h200, "store_f3_2");

        // A rejected data request blocks the fetch on that edge only.
        bus.if_req = 1'b1;
        bus.if_addr = 32'h500;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_funct3 = 3'b010;
        bus.d_addr = 32'h201;
        push(1'b1, 1'b1, 1'b0, 32'd0);
        push(1'b0, 1'b0, 1'b1, 32'h0BAD_F00D);
        tick();
        chk("rej_fetch_blocked", 32'(bus.mem_req), 32'd0);
        chk("rej_fetch_d_err", 32'(bus.d_err), 32'd1);
        bus.d_req = 1'b0;
        tick();
        chk("rej_fetch_granted", 32'(bus.mem_req), 32'd1);
        chk("rej_fetch_addr", bus.mem_addr, 32'h500);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0BAD_F00D;
        tick();
        chk("rej_fetch_if_ready", 32'(bus.if_ready), 32'd1);
        bus.if_req = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Timeout: mem_ready never arrives.
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_funct3 = 3'b010;
        bus.d_addr = 32'h208;
        push(1'b1, 1'b1, 1'b0, 32'd0);
        tick();
        n = 0;
        while (bus.mem_req && n < 100) begin
            n++;
            tick();
        end
        chk("timeout_cycles", 32'(n), 32'(TIMEOUT));
        chk("timeout_d_ready", 32'(bus.d_ready), 32'd1);
        chk("timeout_d_err", 32'(bus.d_err), 32'd1);
        chk("timeout_rdata_hold", bus.d_rdata, exp_d);
        bus.d_req = 1'b0;
        tick();

        // Reset in FETCH abandons the access; the held request is re-granted afterwards.
        bus.if_req = 1'b1;
        bus.if_addr = 32'h600;
        tick();
        chk("rstf_mem_req_before", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstf_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rstf_busy", 32'(bus.busy), 32'd0);
        chk("rstf_if_rdata", bus.if_rdata, 32'd0);
        chk("rstf_d_rdata", bus.d_rdata, 32'd0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h2468_ACE0;
        tick();
        tick();
        chk("rstf_no_if_ready", 32'(bus.if_ready), 32'd0);
        bus.mem_ready = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_rst_grant", 32'(bus.mem_req), 32'd1);
        chk("post_rst_addr", bus.mem_addr, 32'h600);
        push(1'b0, 1'b0, 1'b1, 32'h1357_9BDF);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1357_9BDF;
        tick();
        chk("post_rst_if_ready", 32'(bus.if_ready), 32'd1);
        bus.if_req = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        tick();

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
